chaotic_lorenz_src: RTL and testbench
=====================================

// Module: chaotic_lorenz_src
// PURPOSE
//  Chaotic-state source feeding the DC_DDS_TOP channel inputs (x, y, z, valid).
//  Answers each iteration request from the DDS (chaotic_ctrl) with one Euler step
//  of the Lorenz system in signed Q8.24, then pulses chaotic_valid with the new
//  state. Outputs are offset-binary so the x MSBs can act directly as the DDS
//  period-count field.
// PARAMETERS
//  PHASE_WIDTH  32            state/output width; fixed at 32 (Q8.24), other values unsupported
//  H_SHIFT      7             Euler step h = 2^-H_SHIFT, implemented as an arithmetic right shift
//  SIGMA        10            Lorenz sigma, small unsigned integer
//  RHO          28            Lorenz rho, integer
//  BETA_Q       32'h02AAAAAB  Lorenz beta in Q8.24 (8/3)
//  INIT_X/Y/Z   32'h01000000  reset state in Q8.24 (1.0)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous reset, active-high
//  chaotic_ctrl   in   1   iteration request, 1-cycle pulse from the DDS
//  chaotic_valid  out  1   1-cycle pulse; new x/y/z valid in the same cycle
//  chaotic_x      out  32  x state, offset-binary (Q8.24 with MSB inverted)
//  chaotic_y      out  32  y state, offset-binary
//  chaotic_z      out  32  z state, offset-binary
//  busy           out  1   high while an iteration is in progress
//  overrun        out  1   sticky; a request was dropped
// BEHAVIOUR
//  Reset
//   - state <= INIT_X/Y/Z; chaotic_x/y/z = INIT ^ 32'h80000000.
//   - chaotic_valid = 0, busy = 0, pending = 0, overrun = 0, FSM = IDLE.
//   - rst takes priority at any point: an iteration in flight is abandoned and no valid is emitted.
//  FSM: IDLE -> MUL1 -> MUL2 -> MUL3 -> UPD -> IDLE
//   - IDLE: leave on chaotic_ctrl == 1 or pending == 1; clear pending on leaving.
//   - MUL1: m1 = x * (RHO - z).
//   - MUL2: m2 = x * y.
//   - MUL3: m3 = BETA_Q * z.
//   - UPD: compute the new state, register the outputs, assert chaotic_valid for exactly one cycle.
//   - busy = 1 in MUL1..UPD.
//  Latency: chaotic_ctrl sampled at edge N -> chaotic_valid = 1 and new x/y/z in the cycle after edge N+4.
//   - Throughput: one iteration per 5 cycles.
//  Arithmetic
//   - One shared signed 32x32 -> 64 multiplier.
//   - Q8.24 result = product[55:24] (floor); saturate to 0x7FFFFFFF / 0x80000000 if product[63:55] is not all-equal.
//   - dx = SIGMA*(y - x), built as shift-adds.
//   - dy = m1 - y.
//   - dz = m2 - m3.
//   - new = old + (d >>> H_SHIFT).
//   - Every add/sub saturates to 32-bit signed; no wrap-around anywhere.
//  Requests
//   - chaotic_ctrl while busy: set pending (one deep); serviced on the cycle after UPD, so valids are spaced 5 cycles apart.
//   - chaotic_ctrl while busy with pending already set: the request is dropped and overrun <= 1. overrun is cleared only by rst.
//   - chaotic_ctrl in the UPD cycle: treated as busy, i.e. it goes to pending.
//  Outputs hold their value between valid pulses.
// TESTING
//  1. Reset values: release rst -> x = y = z = 0x81000000, valid/busy/overrun = 0; no valid for 20 idle cycles.
//  2. Single step from reset: one ctrl pulse -> exactly one valid, 5 cycles later, with x = 0x81000000, y = 0x81340000, z = 0x80FCAAAA.
//  3. Back-to-back requests: ctrl at N and N+2 -> valids at N+5 and N+10; overrun stays 0.
//  4. Overrun: ctrl at N, N+1, N+2 -> two valids only (N+5, N+10); overrun = 1 from N+3 until rst.
//  5. Saturation: INIT_Y = 0x7F000000, INIT_X = 0x81000000 (-127.0), SIGMA = 10 -> dx saturates; x output stays within the signed range and does not wrap.
//  6. Reset mid-step: rst asserted in the MUL2 cycle -> no valid pulse; outputs return to INIT values; next ctrl behaves exactly as in test 2.

Source files
------------

// File: rtl/chaotic_lorenz_src.sv
// rtl/chaotic_lorenz_src.sv - Lorenz-system Euler-step chaotic source for the DDS channel inputs
module chaotic_lorenz_src #(
  parameter int          PHASE_WIDTH = 32,
  parameter int          H_SHIFT     = 7,
  parameter int          SIGMA       = 10,
  parameter int          RHO         = 28,
  parameter logic [31:0] BETA_Q      = 32'h02AAAAAB,
  parameter logic [31:0] INIT_X      = 32'h01000000,
  parameter logic [31:0] INIT_Y      = 32'h01000000,
  parameter logic [31:0] INIT_Z      = 32'h01000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   chaotic_ctrl,
  output logic                   chaotic_valid,
  output logic [PHASE_WIDTH-1:0] chaotic_x,
  output logic [PHASE_WIDTH-1:0] chaotic_y,
  output logic [PHASE_WIDTH-1:0] chaotic_z,
  output logic                   busy,
  output logic                   overrun
);

  localparam logic [31:0] SIGN_BIT = 32'h80000000;
  localparam logic [31:0] SAT_MAX  = 32'h7FFFFFFF;
  localparam logic [31:0] SAT_MIN  = 32'h80000000;
  // rho as a Q8.24 constant; rho is a small integer so the shift cannot lose bits
  localparam logic [31:0] RHO_Q    = 32'(RHO) << 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_MUL2,
    S_MUL3,
    S_UPD
  } state_t;

  // Clamp a widened result back into the signed 32-bit range
  function automatic logic signed [31:0] sat48(input logic signed [47:0] v);
    if (v[47:31] == {17{v[47]}}) begin
      return v[31:0];
    end else if (v[47]) begin
      return SAT_MIN;
    end else begin
      return SAT_MAX;
    end
  endfunction

  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic [47:0] s;
    s = {{16{a[31]}}, a} + {{16{b[31]}}, b};
    return sat48(s);
  endfunction

  function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic [47:0] s;
    s = {{16{a[31]}}, a} - {{16{b[31]}}, b};
    return sat48(s);
  endfunction

  // sigma * v as constant shift-adds; 48 bits hold any sigma below 2^16 without overflow
  function automatic logic signed [31:0] sigma_mul(input logic signed [31:0] v);
    logic [47:0] acc;
    logic [47:0] ext;
    acc = '0;
    ext = {{16{v[31]}}, v};
    for (int i = 0; i < 16; i++) begin
      if (SIGMA[i]) begin
        acc = acc + (ext << i);
      end
    end
    return sat48(acc);
  endfunction

  state_t             state_q, state_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [31:0] m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;

  logic signed [31:0] mul_a, mul_b;
  logic signed [63:0] prod;
  logic signed [31:0] prod_fix;
  logic signed [31:0] rho_minus_z, diff_yx, dx, dy, dz;
  logic               unused_prod_lsbs;

  assign rho_minus_z = sat_sub($signed(RHO_Q), z_q);
  assign diff_yx     = sat_sub(y_q, x_q);
  assign dx          = sigma_mul(diff_yx);
  assign dy          = sat_sub(m1_q, y_q);
  assign dz          = sat_sub(m2_q, m3_q);

  // Operand select for the single shared multiplier, one product per MUL state
  always_comb begin
    mul_a = x_q;
    mul_b = y_q;
    case (state_q)
      S_MUL1:  mul_b = rho_minus_z;
      S_MUL3: begin
        mul_a = $signed(BETA_Q);
        mul_b = z_q;
      end
      default: ;
    endcase
  end

  assign prod     = mul_a * mul_b;
  // Q16.48 product back to Q8.24 by flooring; saturate when the integer part overflows
  assign prod_fix = (prod[63:55] == {9{prod[63]}}) ? prod[55:24]
                  : (prod[63] ? SAT_MIN : SAT_MAX);
  assign unused_prod_lsbs = ^prod[23:0];

  // Next-state logic: sequencing, request queueing and the Euler update
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    valid_d   = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    m1_d      = m1_q;
    m2_d      = m2_q;
    m3_d      = m3_q;
    case (state_q)
      S_IDLE: begin
        if (chaotic_ctrl || pending_q) begin
          state_d   = S_MUL1;
          // a fresh request arriving while the pending one is taken stays queued
          pending_d = chaotic_ctrl && pending_q;
        end
      end
      S_MUL1: begin
        m1_d    = prod_fix;
        state_d = S_MUL2;
      end
      S_MUL2: begin
        m2_d    = prod_fix;
        state_d = S_MUL3;
      end
      S_MUL3: begin
        m3_d    = prod_fix;
        state_d = S_UPD;
      end
      S_UPD: begin
        x_d     = sat_add(x_q, dx >>> H_SHIFT);
        y_d     = sat_add(y_q, dy >>> H_SHIFT);
        z_d     = sat_add(z_q, dz >>> H_SHIFT);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && chaotic_ctrl) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  // State registers; reset abandons any iteration in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      x_q       <= INIT_X;
      y_q       <= INIT_Y;
      z_q       <= INIT_Z;
      m1_q      <= '0;
      m2_q      <= '0;
      m3_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      m1_q      <= m1_d;
      m2_q      <= m2_d;
      m3_q      <= m3_d;
    end
  end

  assign chaotic_valid = valid_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;
  assign chaotic_x     = x_q ^ SIGN_BIT;
  assign chaotic_y     = y_q ^ SIGN_BIT;
  assign chaotic_z     = z_q ^ SIGN_BIT;

endmodule

// File: tb/tb_chaotic_lorenz_src.sv
// tb/tb_chaotic_lorenz_src.sv - randomized self-checking bench for chaotic_lorenz_src
module tb_chaotic_lorenz_src;

  localparam longint INIT_Q = 64'h01000000;
  localparam longint BETA   = 64'h02AAAAAB;
  localparam longint SIGMA  = 10;
  localparam longint RHO    = 28;
  localparam int     HS     = 7;

  logic        clk = 1'b0;
  logic        rst, ctrl, ctrl2;
  logic        valid, busy, ovr;
  logic [31:0] cx, cy, cz;
  logic        valid2, busy2, ovr2;
  logic [31:0] cx2, cy2, cz2;

  int checks = 0;
  int errors = 0;

  longint mx, my, mz;
  int          vpos[$];
  logic [31:0] vx[$], vy[$], vz[$];
  logic        ov[0:14];
  logic        bz[0:14];

  always #5 clk = ~clk;

  chaotic_lorenz_src dut (
    .clk(clk), .rst(rst), .chaotic_ctrl(ctrl), .chaotic_valid(valid),
    .chaotic_x(cx), .chaotic_y(cy), .chaotic_z(cz), .busy(busy), .overrun(ovr)
  );

  chaotic_lorenz_src #(.INIT_X(32'h81000000), .INIT_Y(32'h7F000000)) dut_sat (
    .clk(clk), .rst(rst), .chaotic_ctrl(ctrl2), .chaotic_valid(valid2),
    .chaotic_x(cx2), .chaotic_y(cy2), .chaotic_z(cz2), .busy(busy2), .overrun(ovr2)
  );

  function automatic longint clamp(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint mulq(input longint a, input longint b);
    return clamp((a * b) >>> 24);
  endfunction

  function automatic logic [31:0] enc(input longint v);
    logic [31:0] t;
    t = v[31:0];
    return t ^ 32'h80000000;
  endfunction

  // One Euler step of the Lorenz system on real-valued Q8.24 numbers with clamping
  task automatic model_step(input longint x, input longint y, input longint z,
                            output longint nx, output longint ny, output longint nz);
    longint dx, dy, dz;
    dx = clamp(SIGMA * clamp(y - x));
    dy = clamp(mulq(x, clamp(RHO * 64'sd16777216 - z)) - y);
    dz = clamp(mulq(x, y) - mulq(BETA, z));
    nx = clamp(x + (dx >>> HS));
    ny = clamp(y + (dy >>> HS));
    nz = clamp(z + (dz >>> HS));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Request at edge 0, extra requests at edges k2/k3 (0 = none); log 14 edges afterwards
  task automatic burst(input int k2, input int k3);
    vpos.delete(); vx.delete(); vy.delete(); vz.delete();
    ctrl = 1'b1;
    step();
    ctrl = 1'b0;
    ov[0] = ovr;
    bz[0] = busy;
    for (int e = 1; e <= 14; e++) begin
      ctrl = (e == k2) || (e == k3);
      step();
      ctrl = 1'b0;
      ov[e] = ovr;
      bz[e] = busy;
      if (valid) begin
        vpos.push_back(e);
        vx.push_back(cx);
        vy.push_back(cy);
        vz.push_back(cz);
      end
    end
  endtask

  task automatic test_reset();
    int nvalid;
    rst = 1'b1; ctrl = 1'b0; ctrl2 = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++; if (cx !== 32'h81000000) begin errors++; $display("FAIL reset_x got %h want 81000000", cx); end
    checks++; if (cy !== 32'h81000000) begin errors++; $display("FAIL reset_y got %h want 81000000", cy); end
    checks++; if (cz !== 32'h81000000) begin errors++; $display("FAIL reset_z got %h want 81000000", cz); end
    checks++; if ({valid, busy, ovr} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {valid, busy, ovr}); end
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid) nvalid++;
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL idle_valids got %0d want 0", nvalid); end
    mx = INIT_Q; my = INIT_Q; mz = INIT_Q;
  endtask

  task automatic test_single_step();
    int lat;
    ctrl = 1'b1;
    step();
    ctrl = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    wait_valid(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL single_latency got %0d want 4", lat); end
    checks++; if (cx !== 32'h81000000) begin errors++; $display("FAIL single_x got %h want 81000000", cx); end
    checks++; if (cy !== 32'h81340000) begin errors++; $display("FAIL single_y got %h want 81340000", cy); end
    checks++; if (cz !== 32'h80FCAAAA) begin errors++; $display("FAIL single_z got %h want 80FCAAAA", cz); end
    step();
    checks++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL single_pulse_end got %b want 00", {valid, busy}); end
    model_step(mx, my, mz, mx, my, mz);
  endtask

  task automatic test_back_to_back();
    burst(2, 0);
    checks++; if (vpos.size() != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", vpos.size()); end
    for (int i = 0; i < vpos.size(); i++) begin
      model_step(mx, my, mz, mx, my, mz);
      checks++; if (vpos[i] != 4 + 5 * i) begin errors++; $display("FAIL b2b_pos%0d got %0d want %0d", i, vpos[i], 4 + 5 * i); end
      checks++; if ({vx[i], vy[i], vz[i]} !== {enc(mx), enc(my), enc(mz)})
        begin errors++; $display("FAIL b2b_xyz%0d got %h %h %h want %h %h %h", i, vx[i], vy[i], vz[i], enc(mx), enc(my), enc(mz)); end
    end
    checks++; if (ov[14] !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", ov[14]); end
  endtask

  task automatic test_overrun();
    burst(1, 2);
    checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", ov[1]); end
    checks++; if (ov[2] !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", ov[2]); end
    checks++; if (vpos.size() != 2) begin errors++; $display("FAIL ovr_count got %0d want 2", vpos.size()); end
    for (int i = 0; i < vpos.size(); i++) begin
      model_step(mx, my, mz, mx, my, mz);
      checks++; if (vpos[i] != 4 + 5 * i) begin errors++; $display("FAIL ovr_pos%0d got %0d want %0d", i, vpos[i], 4 + 5 * i); end
      checks++; if ({vx[i], vy[i], vz[i]} !== {enc(mx), enc(my), enc(mz)})
        begin errors++; $display("FAIL ovr_xyz%0d got %h %h %h want %h %h %h", i, vx[i], vy[i], vz[i], enc(mx), enc(my), enc(mz)); end
    end
    repeat (5) step();
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", ovr); end
  endtask

  task automatic test_reset_mid_step();
    int nvalid;
    ctrl = 1'b1;
    step();
    ctrl = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({busy, ovr} !== 2'b00) begin errors++; $display("FAIL mid_rst_flags got %b want 00", {busy, ovr}); end
    checks++; if ({cx, cy, cz} !== {3{32'h81000000}}) begin errors++; $display("FAIL mid_rst_xyz got %h %h %h want 81000000", cx, cy, cz); end
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid) nvalid++;
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL mid_rst_valids got %0d want 0", nvalid); end
    mx = INIT_Q; my = INIT_Q; mz = INIT_Q;
    test_single_step();
  endtask

  task automatic test_random();
    int dbl, k;
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 5)) step();
      dbl = int'($urandom_range(0, 1));
      k = int'($urandom_range(1, 4));
      burst(dbl != 0 ? k : 0, 0);
      checks++; if (vpos.size() != 1 + dbl) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", it, vpos.size(), 1 + dbl); end
      for (int i = 0; i < vpos.size(); i++) begin
        model_step(mx, my, mz, mx, my, mz);
        checks++; if (vpos[i] != 4 + 5 * i) begin errors++; $display("FAIL rnd%0d_pos%0d got %0d want %0d", it, i, vpos[i], 4 + 5 * i); end
        checks++; if ({vx[i], vy[i], vz[i]} !== {enc(mx), enc(my), enc(mz)})
          begin errors++; $display("FAIL rnd%0d_xyz%0d got %h %h %h want %h %h %h", it, i, vx[i], vy[i], vz[i], enc(mx), enc(my), enc(mz)); end
      end
      checks++; if (ov[14] !== 1'b0) begin errors++; $display("FAIL rnd%0d_overrun got %b want 0", it, ov[14]); end
    end
  endtask

  task automatic test_saturation();
    longint sx, sy, sz;
    int lat;
    logic signed [31:0] xs;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    mx = INIT_Q; my = INIT_Q; mz = INIT_Q;
    sx = -64'sd2130706432;
    sy = 64'h7F000000;
    sz = INIT_Q;
    for (int it = 0; it < 3; it++) begin
      ctrl2 = 1'b1;
      step();
      ctrl2 = 1'b0;
      checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL sat%0d_busy got %b want 1", it, busy2); end
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        step();
        if (valid2) begin
          lat = i;
          break;
        end
      end
      checks++; if (lat != 4) begin errors++; $display("FAIL sat%0d_latency got %0d want 4", it, lat); end
      model_step(sx, sy, sz, sx, sy, sz);
      checks++; if ({cx2, cy2, cz2} !== {enc(sx), enc(sy), enc(sz)})
        begin errors++; $display("FAIL sat%0d_xyz got %h %h %h want %h %h %h", it, cx2, cy2, cz2, enc(sx), enc(sy), enc(sz)); end
      xs = cx2 ^ 32'h80000000;
      checks++; if (!(xs > -32'sd2130706432 && xs < 0))
        begin errors++; $display("FAIL sat%0d_x_range got %h want between 81000000 and 00000000 exclusive", it, xs); end
      step();
    end
    checks++; if (ovr2 !== 1'b0) begin errors++; $display("FAIL sat_overrun got %b want 0", ovr2); end
  endtask

  initial begin
    rst = 1'b1; ctrl = 1'b0; ctrl2 = 1'b0;
    test_reset();
    test_single_step();
    test_back_to_back();
    test_overrun();
    test_reset_mid_step();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
